// File: rtl/run_monitor_if.sv
// run_monitor_if: retirement stream and halt handshake between the CPU core
// and the run-control monitor.
//   pc / pc_valid : instruction retiring this cycle (core -> monitor)
//   halt_req      : monitor asks the core to halt      (monitor -> core)
//   halt_ack      : core confirms it has halted        (core -> monitor)
//   halted        : monitor reports the core is halted (monitor -> core)
interface run_monitor_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic            halt_req;
  logic            halt_ack;
  logic            halted;

  modport master (output pc, pc_valid, halt_ack, input halt_req, halted);
  modport slave  (input pc, pc_valid, halt_ack, output halt_req, halted);
endinterface

// File: rtl/run_monitor.sv
// run_monitor: run-control monitor beside the CPU core. Counts RUN cycles and
// retirements, matches retiring PCs against NUM_BP breakpoint channels,
// enforces an optional cycle budget, accepts an external stop, and halts the
// core via a req/ack handshake. Supports resume and restart.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   start        : pulse, clear counters/cause and enter RUN (any state)
//   core         : slave side of run_monitor_if (pc, pc_valid, halt_ack in;
//                  halt_req, halted out)
//   bp_addr      : channel i address at [i*XLEN +: XLEN]
//   bp_en        : per-channel enable
//   max_cycles   : cycle budget, 0 disables timeout
//   ext_stop     : external stop level, sampled in RUN
//   resume       : pulse, HALTED -> RUN keeping counters
//   cause        : 00 none, 01 breakpoint, 10 timeout, 11 external
//   hit_vec      : channels matching on the stop cycle
//   cycle_cnt    : saturating RUN cycle count since start
//   retire_cnt   : saturating RUN retirement count since start
module run_monitor #(
  parameter int XLEN   = 32,
  parameter int NUM_BP = 4,
  parameter int CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  run_monitor_if.slave           core,
  input  logic [NUM_BP*XLEN-1:0] bp_addr,
  input  logic [NUM_BP-1:0]      bp_en,
  input  logic [CNT_W-1:0]       max_cycles,
  input  logic                   ext_stop,
  input  logic                   resume,
  output logic [1:0]             cause,
  output logic [NUM_BP-1:0]      hit_vec,
  output logic [CNT_W-1:0]       cycle_cnt,
  output logic [CNT_W-1:0]       retire_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, STOP_PEND, HALTED} state_t;

  state_t            state, state_d;
  logic [NUM_BP-1:0] bp_hit;
  logic              bp_mask;   // suppress matching on first retirement after resume
  logic              timeout;
  logic              stop;
  logic [1:0]        cause_d;

  for (genvar i = 0; i < NUM_BP; i++) begin : g_bp
    assign bp_hit[i] = core.pc_valid & bp_en[i] & ~bp_mask &
                       (core.pc == bp_addr[i*XLEN +: XLEN]);
  end

  // Fires on the cycle that becomes the max_cycles-th counted cycle.
  assign timeout = (max_cycles != '0) && (cycle_cnt == max_cycles - 1'b1);
  assign stop    = (state == RUN) && ((|bp_hit) || timeout || ext_stop);

  always_comb begin
    state_d = state;
    cause_d = 2'b11;
    if (|bp_hit)      cause_d = 2'b01;
    else if (timeout) cause_d = 2'b10;
    if (start) begin
      state_d = RUN;
    end else begin
      unique case (state)
        IDLE:      state_d = IDLE;
        RUN:       if (stop) state_d = STOP_PEND;
        STOP_PEND: if (core.halt_ack) state_d = HALTED;
        HALTED:    if (resume) state_d = RUN;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cycle_cnt     <= '0;
      retire_cnt    <= '0;
      cause         <= 2'b00;
      hit_vec       <= '0;
      bp_mask       <= 1'b0;
      core.halt_req <= 1'b0;
      core.halted   <= 1'b0;
    end else begin
      state         <= state_d;
      core.halt_req <= (state_d == STOP_PEND);
      core.halted   <= (state_d == HALTED);
      if (start) begin
        cycle_cnt  <= '0;
        retire_cnt <= '0;
        cause      <= 2'b00;
        hit_vec    <= '0;
        bp_mask    <= 1'b0;
      end else if (state == RUN) begin
        // The stopping cycle is counted too.
        if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
        if (core.pc_valid && retire_cnt != '1) retire_cnt <= retire_cnt + 1'b1;
        if (core.pc_valid) bp_mask <= 1'b0;
        if (stop) begin
          cause   <= cause_d;
          hit_vec <= bp_hit;
        end
      end else if (state == HALTED && resume) begin
        cause   <= 2'b00;
        hit_vec <= '0;
        bp_mask <= 1'b1;
      end
    end
  end
endmodule

// File: doc/run_monitor.md
# run_monitor

Synthesizable run-control monitor that sits beside the CPU core. It counts cycles and retired instructions and compares retiring PCs against NUM_BP programmable breakpoint channels. It also enforces an optional cycle-budget timeout and accepts an external stop, then halts the core through a req/ack handshake. It is the parametrised, in-hardware successor to our bench-level "stop at PC" logic: multiple breakpoints, a timeout, stop-cause reporting and resume.

## Interface
- XLEN, 32: PC / breakpoint address width
- NUM_BP, 4: number of breakpoint channels (≥1)
- CNT_W, 32: width of cycle and retire counters
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  single-cycle pulse: clear counters/cause, enter RUN
- pc  in  XLEN  PC of instruction retiring this cycle
- pc_valid  in  1  pc is a retirement this cycle
- bp_addr  in  NUM_BP*XLEN  channel i address at [i*XLEN +: XLEN]
- bp_en  in  NUM_BP  per-channel enable
- max_cycles  in  CNT_W  cycle budget; 0 disables timeout
- ext_stop  in  1  external stop request (level, sampled in RUN)
- halt_ack  in  1  core acknowledges halt
- resume  in  1  single-cycle pulse: leave HALTED, continue counting
- halt_req  out  1  request core to halt
- halted  out  1  core is halted
- cause  out  2  00 none, 01 breakpoint, 10 timeout, 11 external
- hit_vec  out  NUM_BP  channels that matched at the stop event
- cycle_cnt  out  CNT_W  cycles spent in RUN since start
- retire_cnt  out  CNT_W  pc_valid cycles counted in RUN since start

## Operation
- States: IDLE, RUN, STOP_PEND, HALTED. Reset → IDLE.
- IDLE: no counting. start → RUN, counters and cause/hit_vec cleared.
- RUN: cycle_cnt +1 every cycle; retire_cnt +1 when pc_valid. Both saturate at all-ones and do not wrap.
- Stop detection in RUN, all combinational on the current cycle:
  - bp_hit[i] = pc_valid & bp_en[i] & (pc == bp_addr[i]).
  - timeout = (max_cycles != 0) & (cycle_cnt == max_cycles-1).
  - ext = ext_stop.
- Any stop → STOP_PEND. On that edge, latch cause with priority breakpoint > timeout > external, and latch hit_vec = bp_hit (all matching channels, may be multi-hot; zero if cause ≠ 01).
- The stopping cycle is still counted, including its retirement.
- STOP_PEND: counters frozen; halt_req=1. halt_ack → HALTED. halt_ack outside STOP_PEND is ignored.
- HALTED: halted=1, counters frozen, cause/hit_vec held.
  - resume → RUN with counters retained, cause/hit_vec cleared.
  - start → RUN with counters cleared.
- Breakpoint re-arm: after resume, breakpoint matching is masked for the first pc_valid in RUN. This prevents re-stopping on the instruction that hit. Timeout and ext_stop are not masked.
- start in any state restarts: → RUN, counters cleared, mask cleared. start wins over a simultaneous stop condition, halt_ack or resume.
- resume outside HALTED is ignored.

## Timing
- Reset values: halt_req=0, halted=0, cause=00, hit_vec=0, cycle_cnt=0, retire_cnt=0, state IDLE.
- All outputs are registered.
- halt_req rises one cycle after the stop-condition cycle, and stays high until the halt_ack edge.
- halted rises on the edge that samples halt_ack, and falls on the edge that samples resume/start.
- Timeout: cycle_cnt reads exactly max_cycles while in STOP_PEND/HALTED.
- start→RUN latency is 1 edge. The first counted cycle is the cycle after start.
- Reset asserted mid-operation: immediate return to reset values regardless of handshake phase.

## Test plan
- Breakpoint: bp_en=0001, bp_addr[0]=0x40, start, retire 0x00,0x04,…,0x40 one per cycle → halt_req next cycle, cause=01, hit_vec=0001, retire_cnt=17, cycle_cnt=17; halt_ack → halted=1, counters frozen.
- Multi-hit + resume: bp_addr[1]=bp_addr[2]=0x10, bp_en=0110 → hit_vec=0110, cause=01. Ack, then resume with pc=0x10 retiring again → no stop. Next retirement of 0x10 → stops again.
- Timeout: max_cycles=5, no retirements, start → halt_req on the cycle after 5th counted cycle, cause=10, cycle_cnt=5, retire_cnt=0. max_cycles=0 → runs 1000 cycles with no stop.
- Priority/simultaneous: in one cycle drive bp hit, cycle_cnt==max_cycles-1 and ext_stop → cause=01. Repeat with start in the same cycle → stays RUN, counters=0.
- Saturation: CNT_W=4, max_cycles=0, pc_valid=1 for 20 cycles → cycle_cnt=retire_cnt=15, no wrap.
- Reset mid-handshake: assert reset while in STOP_PEND with halt_req=1 → asynchronously halt_req=0, cause=00, counters=0, IDLE; start afterward resumes normal counting.
